// File: rtl/ntt_pwo_sequencer.sv
// ---------------------------------------------------------------------------
// ntt_pwo_sequencer
// Runs one point-wise operation (PWM / PWA / PWS, optionally masked,
// optionally accumulating) over a 64-word polynomial. It issues the operand
// reads, the datapath enable and, after the mode-dependent datapath latency,
// the destination writes.
//
// Ports
//   clk, reset_n (sync, active low), zeroize (sync clear)
//   pwo_start_i, mode_i, accumulate_i, masking_en_i, pw_base_addr_i {a,b,c}
//   rd_en_o, rd_addr_a_o, rd_addr_b_o, rd_en_c_o, rd_addr_c_o  : operand reads
//   pw_enable_o                                                 : datapath valid
//   wr_en_o, wr_addr_o                                          : result writes
//   busy_o, done_o, err_o                                       : status
// All outputs are registered.
// ---------------------------------------------------------------------------
module ntt_pwo_sequencer #(
   parameter int ADDR_W       = 15,
   parameter int NUM_WORDS    = 64,
   parameter int LAT_PWM      = 5,
   parameter int LAT_PWA      = 1,
   parameter int LAT_PWS      = 1,
   parameter int LAT_MPWM     = 211,
   parameter int LAT_MPWM_ACC = 264,
   parameter int LAT_MADD     = 53
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  zeroize,
   input  logic                  pwo_start_i,
   input  logic [2:0]            mode_i,
   input  logic                  accumulate_i,
   input  logic                  masking_en_i,
   input  logic [3*ADDR_W-1:0]   pw_base_addr_i,
   output logic                  rd_en_o,
   output logic [ADDR_W-1:0]     rd_addr_a_o,
   output logic [ADDR_W-1:0]     rd_addr_b_o,
   output logic                  rd_en_c_o,
   output logic [ADDR_W-1:0]     rd_addr_c_o,
   output logic                  pw_enable_o,
   output logic                  wr_en_o,
   output logic [ADDR_W-1:0]     wr_addr_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   // mode_t encoding shared with the NTT control FSM
   localparam logic [2:0] MODE_PWM = 3'd2;
   localparam logic [2:0] MODE_PWA = 3'd3;
   localparam logic [2:0] MODE_PWS = 3'd4;

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   // Counter must hold the largest latency of any mode
   localparam int LAT_MAX = (LAT_MPWM_ACC > LAT_MPWM) ?
                            ((LAT_MPWM_ACC > LAT_MADD) ? LAT_MPWM_ACC : LAT_MADD) :
                            ((LAT_MPWM > LAT_MADD) ? LAT_MPWM : LAT_MADD);
   localparam int LAT_W = $clog2(LAT_MAX + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state_reg;
   logic [IDX_W-1:0]  rd_idx_reg;
   logic [IDX_W-1:0]  wr_idx_reg;
   logic [LAT_W-1:0]  lat_cnt_reg;
   logic [ADDR_W-1:0] base_c_reg;

   logic              start_legal;
   logic              acc_sel;
   logic [LAT_W-1:0]  lat_sel;

   always_comb begin
      start_legal = (mode_i == MODE_PWM) || (mode_i == MODE_PWA) || (mode_i == MODE_PWS);
      // accumulate only has meaning for multiply; c is never read otherwise
      acc_sel     = accumulate_i && (mode_i == MODE_PWM);
      lat_sel     = LAT_W'(LAT_PWA);
      if (masking_en_i) begin
         if (mode_i == MODE_PWM)
            lat_sel = acc_sel ? LAT_W'(LAT_MPWM_ACC) : LAT_W'(LAT_MPWM);
         else
            lat_sel = LAT_W'(LAT_MADD);
      end else begin
         if (mode_i == MODE_PWM)
            lat_sel = LAT_W'(LAT_PWM);
         else if (mode_i == MODE_PWS)
            lat_sel = LAT_W'(LAT_PWS);
         else
            lat_sel = LAT_W'(LAT_PWA);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || zeroize) begin
         state_reg   <= IDLE;
         rd_idx_reg  <= '0;
         wr_idx_reg  <= '0;
         lat_cnt_reg <= '0;
         base_c_reg  <= '0;
         rd_en_o     <= 1'b0;
         rd_en_c_o   <= 1'b0;
         rd_addr_a_o <= '0;
         rd_addr_b_o <= '0;
         rd_addr_c_o <= '0;
         pw_enable_o <= 1'b0;
         wr_en_o     <= 1'b0;
         wr_addr_o   <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         // memory returns data one cycle after the read strobe
         pw_enable_o <= rd_en_o;

         case (state_reg)
            IDLE: begin
               if (pwo_start_i) begin
                  if (start_legal) begin
                     state_reg   <= READ;
                     busy_o      <= 1'b1;
                     rd_en_o     <= 1'b1;
                     rd_en_c_o   <= acc_sel;
                     rd_idx_reg  <= '0;
                     wr_idx_reg  <= '0;
                     lat_cnt_reg <= lat_sel;
                     rd_addr_a_o <= pw_base_addr_i[3*ADDR_W-1:2*ADDR_W];
                     rd_addr_b_o <= pw_base_addr_i[2*ADDR_W-1:ADDR_W];
                     rd_addr_c_o <= pw_base_addr_i[ADDR_W-1:0];
                     base_c_reg  <= pw_base_addr_i[ADDR_W-1:0];
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end

            READ, DRAIN: begin
               if (state_reg == READ) begin
                  if (rd_idx_reg == LAST_IDX) begin
                     rd_en_o   <= 1'b0;
                     rd_en_c_o <= 1'b0;
                     state_reg <= DRAIN;
                  end else begin
                     rd_idx_reg  <= rd_idx_reg + IDX_W'(1);
                     rd_addr_a_o <= rd_addr_a_o + ADDR_W'(1);
                     rd_addr_b_o <= rd_addr_b_o + ADDR_W'(1);
                     rd_addr_c_o <= rd_addr_c_o + ADDR_W'(1);
                  end
               end

               // Latency countdown runs in parallel with the reads; when it
               // expires the write stream starts and stays on for 64 words.
               // Writes always outlast reads, so a DONE here overrides DRAIN.
               if (lat_cnt_reg != '0) begin
                  lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
               end else if (!wr_en_o) begin
                  wr_en_o    <= 1'b1;
                  wr_addr_o  <= base_c_reg;
                  wr_idx_reg <= '0;
               end else if (wr_idx_reg == LAST_IDX) begin
                  wr_en_o   <= 1'b0;
                  done_o    <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  wr_idx_reg <= wr_idx_reg + IDX_W'(1);
                  wr_addr_o  <= wr_addr_o + ADDR_W'(1);
               end
            end

            DONE: begin
               busy_o    <= 1'b0;
               state_reg <= IDLE;
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_pwo_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ntt_pwo_sequencer
// Cycle-window reference model plus directed and random operations.
// ---------------------------------------------------------------------------
module tb_ntt_pwo_sequencer;
   localparam int AW = 15;
   localparam logic [2:0] M_CT  = 3'd0;
   localparam logic [2:0] M_PWM = 3'd2;
   localparam logic [2:0] M_PWA = 3'd3;
   localparam logic [2:0] M_PWS = 3'd4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            zeroize;
   logic            pwo_start_i;
   logic [2:0]      mode_i;
   logic            accumulate_i;
   logic            masking_en_i;
   logic [3*AW-1:0] pw_base_addr_i;
   logic            rd_en_o;
   logic [AW-1:0]   rd_addr_a_o;
   logic [AW-1:0]   rd_addr_b_o;
   logic            rd_en_c_o;
   logic [AW-1:0]   rd_addr_c_o;
   logic            pw_enable_o;
   logic            wr_en_o;
   logic [AW-1:0]   wr_addr_o;
   logic            busy_o;
   logic            done_o;
   logic            err_o;

   always #5 clk = ~clk;

   ntt_pwo_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .zeroize        (zeroize),
      .pwo_start_i    (pwo_start_i),
      .mode_i         (mode_i),
      .accumulate_i   (accumulate_i),
      .masking_en_i   (masking_en_i),
      .pw_base_addr_i (pw_base_addr_i),
      .rd_en_o        (rd_en_o),
      .rd_addr_a_o    (rd_addr_a_o),
      .rd_addr_b_o    (rd_addr_b_o),
      .rd_en_c_o      (rd_en_c_o),
      .rd_addr_c_o    (rd_addr_c_o),
      .pw_enable_o    (pw_enable_o),
      .wr_en_o        (wr_en_o),
      .wr_addr_o      (wr_addr_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // An operation is described by k = cycles since the start edge (k=1 is the
   // first cycle after start) and its latency L; every output is a window in k.
   bit            m_act;
   int            m_k;
   int            m_L;
   bit            m_acc;
   bit            m_err;
   logic [AW-1:0] m_ba, m_bb, m_bc;
   logic [AW-1:0] m_ra, m_rb, m_rc;
   bit            chk_on = 1'b0;

   function automatic int model_lat(input logic [2:0] md, input bit acc, input bit mk);
      if (!mk) return (md == M_PWM) ? 5 : 1;
      if (md == M_PWM) return acc ? 264 : 211;
      return 53;
   endfunction

   always @(posedge clk) begin
      if (!reset_n || zeroize) begin
         m_act = 1'b0; m_k = 0; m_err = 1'b0;
         m_ra = '0; m_rb = '0; m_rc = '0;
      end else begin
         m_err = 1'b0;
         if (m_act) begin
            m_k++;
            if (m_k > m_L + 66) m_act = 1'b0;
         end else if (pwo_start_i) begin
            if (mode_i == M_PWM || mode_i == M_PWA || mode_i == M_PWS) begin
               m_act = 1'b1;
               m_k   = 1;
               m_acc = accumulate_i && (mode_i == M_PWM);
               m_L   = model_lat(mode_i, m_acc, masking_en_i);
               m_ba  = pw_base_addr_i[3*AW-1:2*AW];
               m_bb  = pw_base_addr_i[2*AW-1:AW];
               m_bc  = pw_base_addr_i[AW-1:0];
            end else begin
               m_err = 1'b1;
            end
         end
         if (m_act && m_k <= 64) begin
            m_ra = m_ba + AW'(m_k - 1);
            m_rb = m_bb + AW'(m_k - 1);
            m_rc = m_bc + AW'(m_k - 1);
         end
      end
   end

   always @(negedge clk) begin : compare
      bit            e_rd, e_wr;
      logic [AW-1:0] e_wa;
      if (chk_on) begin
         e_rd = m_act && (m_k <= 64);
         e_wr = m_act && (m_k >= m_L + 2) && (m_k <= m_L + 65);
         e_wa = m_bc + AW'(m_k - m_L - 2);
         chk("rd_en",     int'(rd_en_o),     int'(e_rd));
         chk("rd_en_c",   int'(rd_en_c_o),   int'(e_rd && m_acc));
         chk("rd_addr_a", int'(rd_addr_a_o), int'(m_ra));
         chk("rd_addr_b", int'(rd_addr_b_o), int'(m_rb));
         chk("rd_addr_c", int'(rd_addr_c_o), int'(m_rc));
         chk("pw_enable", int'(pw_enable_o), int'(m_act && m_k >= 2 && m_k <= 65));
         chk("wr_en",     int'(wr_en_o),     int'(e_wr));
         if (e_wr) chk("wr_addr", int'(wr_addr_o), int'(e_wa));
         chk("done",      int'(done_o),      int'(m_act && m_k == m_L + 66));
         chk("busy",      int'(busy_o),      int'(m_act));
         chk("err",       int'(err_o),       int'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   // Launches one operation and pins its timing against literal expectations
   // (negative expectation = not pinned). Inputs are scrambled after the start
   // cycle to show that everything was latched.
   task automatic run_op(input logic [2:0] md, input bit acc, input bit mk,
                         input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                         input int e_first, input int e_done, input int e_sawc, input int e_lastwa,
                         input int glitch, input int rst_at, input bit use_zero, input bit done_start);
      int            first, dn;
      bit            sawc;
      logic [AW-1:0] lastwa;
      mode_i         = md;
      accumulate_i   = acc;
      masking_en_i   = mk;
      pw_base_addr_i = {a, b, c};
      pwo_start_i    = 1'b1;
      @(negedge clk);
      pwo_start_i    = 1'b0;
      mode_i         = 3'($urandom);
      accumulate_i   = 1'($urandom);
      masking_en_i   = 1'($urandom);
      pw_base_addr_i = 45'({$urandom(), $urandom()});
      if (!(md == M_PWM || md == M_PWA || md == M_PWS)) begin
         chk("illegal_err", int'(err_o), 1);
         chk("illegal_busy", int'(busy_o), 0);
         @(negedge clk);
         chk("illegal_rd_en", int'(rd_en_o), 0);
         $display("[TB] op mode=%0d illegal start", md);
         return;
      end
      first = -1; dn = -1; sawc = 1'b0; lastwa = '0;
      for (int cyc = 1; cyc <= 500; cyc++) begin
         if (wr_en_o) begin
            if (first < 0) first = cyc;
            lastwa = wr_addr_o;
         end
         if (rd_en_c_o) sawc = 1'b1;
         if (done_o) begin
            dn = cyc;
            pwo_start_i = done_start;
            break;
         end
         pwo_start_i = (cyc == glitch);
         if (cyc == rst_at + 1) begin
            chk("post_reset_busy",  int'(busy_o),  0);
            chk("post_reset_rd_en", int'(rd_en_o), 0);
            chk("post_reset_wr_en", int'(wr_en_o), 0);
            reset_n = 1'b1;
            zeroize = 1'b0;
            break;
         end
         if (cyc == rst_at) begin
            if (use_zero) zeroize = 1'b1;
            else          reset_n = 1'b0;
         end
         @(negedge clk);
      end
      if (rst_at > 0 && dn < 0) begin
         pwo_start_i = 1'b0;
         repeat (3) @(negedge clk);
         $display("[TB] op mode=%0d acc=%0d mask=%0d aborted at cycle %0d", md, acc, mk, rst_at);
         return;
      end
      @(negedge clk);
      pwo_start_i = 1'b0;
      chk("done_seen", int'(dn >= 0), 1);
      if (e_first >= 0)  chk("first_wr_cycle", first, e_first);
      if (e_done >= 0)   chk("done_cycle", dn, e_done);
      if (e_sawc >= 0)   chk("rd_en_c_seen", int'(sawc), e_sawc);
      if (e_lastwa >= 0) chk("last_wr_addr", int'(lastwa), e_lastwa);
      $display("[TB] op mode=%0d acc=%0d mask=%0d c=0x%0h first_wr=%0d done=%0d",
               md, acc, mk, c, first, dn);
   endtask

   initial begin
      reset_n = 1'b0; zeroize = 1'b0; pwo_start_i = 1'b0;
      mode_i = '0; accumulate_i = 1'b0; masking_en_i = 1'b0; pw_base_addr_i = '0;
      @(negedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      chk("reset_busy", int'(busy_o), 0);
      chk("reset_rd_addr_a", int'(rd_addr_a_o), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // pwa with a mid-READ restart attempt and a start during DONE
      run_op(M_PWA, 1'b0, 1'b0, 15'h000, 15'h040, 15'h080, 3, 67, 0, 'h0BF, 10, -1, 1'b0, 1'b1);
      run_op(M_PWM, 1'b1, 1'b0, 15'h200, 15'h300, 15'h100, 7, 71, 1, 'h13F, -1, -1, 1'b0, 1'b0);
      run_op(M_PWM, 1'b1, 1'b1, 15'h400, 15'h500, 15'h600, 266, 330, 1, 'h63F, 100, -1, 1'b0, 1'b0);
      run_op(M_PWS, 1'b1, 1'b1, 15'h010, 15'h020, 15'h030, 55, 119, 0, 'h06F, -1, -1, 1'b0, 1'b0);
      run_op(M_CT,  1'b0, 1'b0, 15'h000, 15'h000, 15'h000, -1, -1, -1, -1, -1, -1, 1'b0, 1'b0);
      run_op(M_PWA, 1'b0, 1'b0, 15'h100, 15'h200, 15'h7FF0, 3, 67, 0, 'h002F, -1, -1, 1'b0, 1'b0);
      run_op(M_PWM, 1'b0, 1'b1, 15'h000, 15'h040, 15'h080, -1, -1, -1, -1, -1, 30, 1'b0, 1'b0);
      run_op(M_PWA, 1'b0, 1'b0, 15'h000, 15'h040, 15'h080, 3, 67, 0, 'h0BF, -1, -1, 1'b0, 1'b0);

      for (int n = 0; n < 12; n++) begin
         logic [2:0] md;
         md = 3'($urandom_range(0, 7));
         run_op(md, 1'($urandom), 1'($urandom),
                AW'($urandom), AW'($urandom), AW'($urandom),
                -1, -1, -1, -1,
                int'($urandom_range(0, 80)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1,
                1'($urandom), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
